// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
//   CPU side : rd_en/wr_en/addr/data_wr in; rdy pulse with hit, word_out and
//              byte_out. Requests are sampled in IDLE only and must be held
//              until rdy.
//   Memory   : mem_addr (block aligned), mem_rd_en with mem_rd_blk returned
//              one edge later, mem_wr_en with mem_wr_blk for write-back.
//   Miss flow: IDLE -> [WB] -> ALLOC -> FILL -> RESP -> IDLE.
//   Hit flow : IDLE -> RESP -> IDLE.
module data_cache #(
  parameter int PA_WIDTH  = 32,
  parameter int WRD_WIDTH = 32,
  parameter int BYTE      = 8,
  parameter int BLK_WIDTH = 512,
  parameter int NUM_SETS  = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [PA_WIDTH-1:0]  addr,
  input  logic [WRD_WIDTH-1:0] data_wr,
  input  logic [BLK_WIDTH-1:0] mem_rd_blk,
  output logic [PA_WIDTH-1:0]  mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [BLK_WIDTH-1:0] mem_wr_blk,
  output logic                 hit,
  output logic [WRD_WIDTH-1:0] word_out,
  output logic [BYTE-1:0]      byte_out,
  output logic                 rdy
);

  localparam int BYTES  = BLK_WIDTH / BYTE;
  localparam int WORDS  = BLK_WIDTH / WRD_WIDTH;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = PA_WIDTH - IDX_W - OFF_W;
  localparam int WSEL_W = $clog2(WORDS);
  localparam int BSEL_W = $clog2(WRD_WIDTH / BYTE);

  typedef enum logic [2:0] {IDLE, RESP, WB, ALLOC, FILL} state_t;

  state_t               state;
  logic                 miss_q;
  logic [NUM_SETS-1:0]  valid;
  logic [NUM_SETS-1:0]  dirty;
  logic [TAG_W-1:0]     tag_arr  [NUM_SETS];
  logic [BLK_WIDTH-1:0] data_arr [NUM_SETS];

  // address split
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] wsel;
  logic [OFF_W-1:0]  bsel;
  assign idx  = addr[OFF_W+IDX_W-1:OFF_W];
  assign tag  = addr[PA_WIDTH-1:OFF_W+IDX_W];
  assign wsel = addr[OFF_W-1:BSEL_W];
  assign bsel = addr[OFF_W-1:0];

  logic req, tag_hit, victim_dirty, line_we;
  logic [PA_WIDTH-1:0] blk_addr, victim_addr;
  assign req          = rd_en | wr_en;
  assign tag_hit      = valid[idx] && (tag_arr[idx] == tag);
  assign victim_dirty = valid[idx] && dirty[idx];
  assign blk_addr     = {addr[PA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign victim_addr  = {tag_arr[idx], idx, {OFF_W{1'b0}}};

  // Line as it looks after this access: the resident line on a hit, the
  // fetched block in FILL, with the write word merged in either case. The
  // same view feeds the array write and the word/byte outputs.
  logic [WORDS-1:0][WRD_WIDTH-1:0] new_words;
  logic [BYTES-1:0][BYTE-1:0]      new_bytes;
  always_comb begin
    new_words = (state == FILL) ? mem_rd_blk : data_arr[idx];
    if (wr_en) new_words[wsel] = data_wr;
    new_bytes = new_words;
  end

  assign line_we = ((state == IDLE) && wr_en && tag_hit) || (state == FILL);

  // Data and tag storage carry no reset; valid bits gate everything.
  always_ff @(posedge clk) begin
    if (line_we)         data_arr[idx] <= new_words;
    if (state == FILL)   tag_arr[idx]  <= tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      miss_q     <= 1'b0;
      valid      <= '0;
      dirty      <= '0;
      rdy        <= 1'b0;
      hit        <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wr_blk <= '0;
      word_out   <= '0;
      byte_out   <= '0;
    end else begin
      // strobes and rdy are single-cycle unless a state re-asserts them
      rdy       <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (tag_hit) begin
              hit      <= 1'b1;
              rdy      <= 1'b1;
              word_out <= new_words[wsel];
              byte_out <= new_bytes[bsel];
              if (wr_en) dirty[idx] <= 1'b1;
              miss_q   <= 1'b0;
              state    <= RESP;
            end else begin
              miss_q <= 1'b1;
              if (victim_dirty) begin
                mem_wr_en  <= 1'b1;
                mem_addr   <= victim_addr;
                mem_wr_blk <= data_arr[idx];
                state      <= WB;
              end else begin
                mem_rd_en <= 1'b1;
                mem_addr  <= blk_addr;
                state     <= ALLOC;
              end
            end
          end
        end
        WB: begin
          mem_rd_en <= 1'b1;
          mem_addr  <= blk_addr;
          state     <= ALLOC;
        end
        // memory captures the block at the edge leaving ALLOC
        ALLOC: state <= FILL;
        FILL: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= wr_en;
          hit        <= ~miss_q;
          rdy        <= 1'b1;
          word_out   <= new_words[wsel];
          byte_out   <= new_bytes[bsel];
          miss_q     <= 1'b0;
          state      <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized scoreboard bench for data_cache.
//   Driver issues requests and pushes the expected response computed from a
//   flat word-addressed memory image plus a per-set residency table; a
//   negedge monitor pops and compares on every rdy pulse, including the
//   memory strobes seen during the access.
module tb_data_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rd_en, wr_en;
  logic [31:0]  addr, data_wr;
  logic [511:0] mem_rd_blk;
  logic [31:0]  mem_addr;
  logic         mem_rd_en, mem_wr_en;
  logic [511:0] mem_wr_blk;
  logic         hit, rdy;
  logic [31:0]  word_out;
  logic [7:0]   byte_out;

  data_cache dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
    .data_wr(data_wr), .mem_rd_blk(mem_rd_blk), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wr_blk(mem_wr_blk),
    .hit(hit), .word_out(word_out), .byte_out(byte_out), .rdy(rdy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- memory device: byte at A = A[7:0] until written
  logic [511:0] bmem [logic [25:0]];

  function automatic logic [511:0] pat_blk(logic [25:0] b);
    logic [511:0] r;
    for (int k = 0; k < 64; k++) r[8*k +: 8] = 8'(k) + {b[1:0], 6'b0};
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_wr_en) bmem[mem_addr[31:6]] = mem_wr_blk;
    if (mem_rd_en)
      mem_rd_blk <= bmem.exists(mem_addr[31:6]) ? bmem[mem_addr[31:6]]
                                                : pat_blk(mem_addr[31:6]);
  end

  // ---------------- reference: latest value of every word + residency
  logic [31:0] ref_mem [logic [29:0]];
  bit   [63:0] mv, md;
  logic [19:0] mt [64];

  function automatic logic [31:0] ref_get(logic [31:0] wa);
    if (ref_mem.exists(wa[31:2])) return ref_mem[wa[31:2]];
    return {wa[7:0] + 8'd3, wa[7:0] + 8'd2, wa[7:0] + 8'd1, wa[7:0]};
  endfunction

  typedef struct {
    logic         hit;
    logic [31:0]  word;
    logic [7:0]   byt;
    int           busy;
    int           nrd;
    logic [31:0]  rd_addr;
    int           nwr;
    logic [31:0]  wr_addr;
    logic [511:0] wr_blk;
  } exp_t;
  exp_t sb[$];

  // ---------------- monitor
  int           busy, nrd, nwr;
  logic [31:0]  cr_addr, cw_addr;
  logic [511:0] cw_blk;
  bit           both, ord_bad;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 0; nrd = 0; nwr = 0; cr_addr = 0; cw_addr = 0; cw_blk = 0;
      both = 0; ord_bad = 0;
    end else begin
      if ((rd_en | wr_en) && !rdy) busy++;
      if (mem_rd_en && mem_wr_en) both = 1;
      if (mem_wr_en) begin
        if (nrd != 0) ord_bad = 1;
        nwr++; cw_addr = mem_addr; cw_blk = mem_wr_blk;
      end
      if (mem_rd_en) begin nrd++; cr_addr = mem_addr; end
      if (rdy) begin
        chk("rdy_has_pending_request", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("hit",        hit,      e.hit);
          chk("word_out",   word_out, e.word);
          chk("byte_out",   byte_out, e.byt);
          chk("latency",    busy,     e.busy);
          chk("rd_strobes", nrd,      e.nrd);
          chk("rd_addr",    cr_addr,  e.rd_addr);
          chk("wr_strobes", nwr,      e.nwr);
          chk("wr_addr",    cw_addr,  e.wr_addr);
          chk("wr_blk",     cw_blk,   e.wr_blk);
          chk("strobes_together",   both,    0);
          chk("writeback_order",    ord_bad, 0);
        end
        busy = 0; nrd = 0; nwr = 0; cr_addr = 0; cw_addr = 0; cw_blk = 0;
        both = 0; ord_bad = 0;
      end
    end
  end

  // ---------------- driver
  task automatic check_reset_outputs(string tag);
    chk({tag, "_rdy"},        rdy,        0);
    chk({tag, "_hit"},        hit,        0);
    chk({tag, "_mem_rd_en"},  mem_rd_en,  0);
    chk({tag, "_mem_wr_en"},  mem_wr_en,  0);
    chk({tag, "_word_out"},   word_out,   0);
    chk({tag, "_byte_out"},   byte_out,   0);
    chk({tag, "_mem_addr"},   mem_addr,   0);
    chk({tag, "_mem_wr_blk"}, mem_wr_blk, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rd_en = 0; wr_en = 0;
    repeat (3) @(posedge clk);
    #1;
    mv = '0; md = '0; sb.delete();
    check_reset_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic issue(bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    exp_t        e;
    logic [5:0]  idx;
    logic [19:0] tg;
    logic [31:0] wa, va, tmp;
    int          n;
    idx = a[11:6]; tg = a[31:12]; wa = {a[31:2], 2'b00};
    e.hit     = mv[idx] && (mt[idx] == tg);
    e.nrd     = e.hit ? 0 : 1;
    e.rd_addr = e.hit ? 32'h0 : {a[31:6], 6'b0};
    e.nwr = 0; e.wr_addr = 0; e.wr_blk = 0;
    if (!e.hit && mv[idx] && md[idx]) begin
      va = {mt[idx], idx, 6'b0};
      e.nwr = 1; e.wr_addr = va;
      for (int w = 0; w < 16; w++) e.wr_blk[32*w +: 32] = ref_get(va + 32'(4*w));
    end
    e.busy = e.hit ? 1 : (e.nwr != 0 ? 4 : 3);
    if (wr) ref_mem[wa[31:2]] = d;
    e.word = ref_get(wa);
    tmp    = e.word >> (8 * a[1:0]);
    e.byt  = tmp[7:0];
    if (e.hit) md[idx] = md[idx] | wr;
    else begin mv[idx] = 1; mt[idx] = tg; md[idx] = wr; end
    sb.push_back(e);

    rd_en = rd; wr_en = wr; addr = a; data_wr = d;
    n = 0;
    do begin @(negedge clk); n++; end while (!rdy && n < 20);
    if (!rdy) begin
      chk("rdy_timeout", rdy, 1);
      do_reset();
    end else begin
      @(posedge clk); #1;
    end
    rd_en = 0; wr_en = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    bit   rdy_seen;
    bit   rd, wr;
    logic [31:0] a;
    rd_en = 0; wr_en = 0; addr = 0; data_wr = 0; rst_n = 1'b0;
    do_reset();

    // directed sequence
    issue(1, 0, 32'h0000_0000, 0);            // cold miss
    issue(1, 0, 32'h0000_0015, 0);            // hits
    issue(1, 0, 32'h0000_0019, 0);
    issue(0, 1, 32'h0000_20D5, 32'hFAFAFAFA); // write miss, clean victim
    issue(0, 1, 32'h0000_20D5, 32'hDADADADA); // write hit
    issue(1, 0, 32'h0000_20D5, 0);
    issue(1, 0, 32'h0000_30D5, 0);            // dirty victim
    issue(1, 0, 32'h0000_20D5, 0);            // written-back data returns

    // reset during ALLOC aborts the access
    rd_en = 1; addr = 32'h0000_1000;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!mem_rd_en && n < 10);
    chk("abort_reached_alloc", mem_rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rd_strobe_drop", mem_rd_en, 0);
    chk("abort_wr_strobe_drop", mem_wr_en, 0);
    rdy_seen = 0;
    rd_en = 0;
    repeat (2) begin @(negedge clk); if (rdy) rdy_seen = 1; end
    check_reset_outputs("abort");
    @(posedge clk); #1 rst_n = 1'b1;
    mv = '0; md = '0;
    repeat (3) begin @(negedge clk); if (rdy) rdy_seen = 1; end
    chk("abort_no_rdy", rdy_seen, 0);
    @(posedge clk); #1;
    issue(1, 0, 32'h0000_1000, 0);            // must miss again

    // random phase: few tags and sets to force hits, conflicts and evictions
    for (int i = 0; i < 300; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1;
      a = {20'($urandom_range(0, 3)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 63))};
      issue(rd, wr, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between a CPU-side word/byte request port and a block-wide main memory.
- Serves single reads and writes with a rdy pulse and a hit flag.
- On a miss it evicts the victim line if dirty, then fetches the whole 64-byte block.
- Main memory is a separate block (mem) with a 1-cycle registered block read; it is not part of this block.

Parameters:
PA_WIDTH, 32, physical byte-address width
WRD_WIDTH, 32, CPU word width
BYTE, 8, byte width
BLK_WIDTH, 512, line/block width (64 bytes, 16 words)
NUM_SETS, 64, number of lines; index = addr[11:6], offset = addr[5:0], tag = addr[31:12]

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
rd_en  in  1  read request
wr_en  in  1  write request (priority over rd_en if both high)
addr  in  PA_WIDTH  byte address of request
data_wr  in  WRD_WIDTH  write data, whole aligned word
mem_rd_blk  in  BLK_WIDTH  block returned by memory
mem_addr  out  PA_WIDTH  block-aligned memory address (addr[5:0]=0)
mem_rd_en  out  1  memory block read strobe
mem_wr_en  out  1  memory block write strobe
mem_wr_blk  out  BLK_WIDTH  victim block for write-back
hit  out  1  request completed as a hit
word_out  out  WRD_WIDTH  aligned word at addr[5:2] after the access
byte_out  out  BYTE  byte at addr[5:0] after the access
rdy  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, rst_n=0):
  - All valid and dirty bits clear; FSM to IDLE.
  - rdy, hit, mem_rd_en and mem_wr_en = 0; word_out, byte_out, mem_addr and mem_wr_blk = 0.
  - Reset mid-operation aborts the access with no rdy, and the line is not filled.
- Little-endian: byte k of a block is bits [8k+7:8k]; word w is bits [32w+31:32w], w = addr[5:2]. addr[1:0] is ignored for writes.
- FSM states: IDLE, RESP, WB, ALLOC, FILL. Requests are sampled only in IDLE; rd_en/wr_en/addr/data_wr must be held stable until rdy.
- IDLE with a hit (valid and tag match), sampled at edge N:
  - Read: outputs are updated from the line.
  - Write: the word is merged into the line and dirty is set; outputs show the new word.
  - At edge N: hit=1, rdy=1, state goes to RESP.
- IDLE with a miss, sampled at edge N:
  - Victim valid and dirty: go to WB. Otherwise go to ALLOC.
  - A miss latches a miss flag.
- WB (one cycle): mem_wr_en=1, mem_addr={victim tag, index, 6'b0}, mem_wr_blk = victim line. Next state ALLOC.
- ALLOC (one cycle): mem_rd_en=1, mem_addr={addr[31:6], 6'b0}. Memory registers the block at the edge ending ALLOC. Next state FILL.
- FILL:
  - Line = mem_rd_blk, with the write word merged if the request is a write.
  - Tag and valid are set; dirty = (request is a write).
  - Outputs are updated, hit=0, rdy=1, next state RESP.
- RESP: rdy=0, next state IDLE. Requests are ignored in RESP, so back-to-back requests have at least one idle cycle between rdy pulses.
- Latency, counted in edges after the sampling edge N:
  - Hit: rdy high in the cycle after edge N.
  - Clean miss: rdy after edge N+2.
  - Dirty miss: rdy after edge N+3.
- hit, word_out and byte_out hold their values until the next completion. No request (rd_en=wr_en=0) keeps the FSM in IDLE.
- mem_rd_en and mem_wr_en are high only in ALLOC and WB respectively, and never together.

Test Plan:
Bench memory model (1-cycle registered read, write on edge) is initialised so that the byte at address A = A[7:0].
1. Reset, then read 0x00 -> one mem_rd_en pulse with mem_addr=0x00; rdy with hit=0, word_out=0x03020100, byte_out=0x00.
2. Read 0x15, then read 0x19 -> both hit=1 with no memory strobes; first gives word_out=0x17161514, byte_out=0x15; second gives word_out=0x1B1A1918, byte_out=0x19.
3. Write miss 0x20D5 with data 0xFAFAFAFA -> mem_rd_en with mem_addr=0x20C0, no mem_wr_en; hit=0, word_out=0xFAFAFAFA, byte_out=0xFA.
4. Write hit 0x20D5 with data 0xDADADADA, then read 0x20D5 -> both hit=1, word_out=0xDADADADA, byte_out=0xDA.
5. Read 0x30D5 (same index, dirty victim) -> first mem_wr_en with mem_addr=0x20C0 and mem_wr_blk word 5 = 0xDADADADA, then mem_rd_en with mem_addr=0x30C0; hit=0, word_out=0xD7D6D5D4, byte_out=0xD5. A following read of 0x20D5 misses and returns 0xDADADADA, which proves the write-back.
6. Assert rst_n=0 during ALLOC -> rdy never pulses, strobes drop at once, and a re-read of the same address misses.
